// File: rtl/button_event_gen_if.sv
// Bundles the tick strobe, button level and event outputs of button_event_gen.
// The master side drives the inputs and observes the events.
// The slave side is the event generator itself.
interface button_event_gen_if;
    logic       tick_ms;
    logic       debounced_p;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] click_count;

    modport master (
        output tick_ms,
        output debounced_p,
        input  press_pulse,
        input  release_pulse,
        input  click_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held,
        input  click_count
    );

    modport slave (
        input  tick_ms,
        input  debounced_p,
        output press_pulse,
        output release_pulse,
        output click_pulse,
        output long_pulse,
        output repeat_pulse,
        output held,
        output click_count
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns the debounced button level into single-cycle events for the game logic:
// press, release, short click, long press and auto-repeat while held.
// Hold time is measured in whole 1 ms strobes, so any partial millisecond
// before the first strobe is ignored. All outputs are registered.
module button_event_gen #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    button_event_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    // Terminal counts are precomputed so the comparisons are plain equality.
    // With repeat disabled the terminal is never consulted.
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'((REPEAT_MS == 0) ? 0 : (REPEAT_MS - 1));
    localparam bit               REPEAT_EN   = (REPEAT_MS != 0);

    logic             w_tick;
    logic             w_level;
    logic             w_rise;
    logic             w_fall;

    logic             r_p_q;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_press_next;
    logic             w_release_next;
    logic             w_click_next;
    logic             w_long_next;
    logic             w_repeat_next;
    logic             w_held_next;
    logic [7:0]       w_click_count_next;

    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic [7:0]       r_click_count;

    assign w_tick  = bus.tick_ms;
    assign w_level = bus.debounced_p;

    // Edges are taken against last cycle's level; after reset the previous
    // level reads as released, so a button already down gives a press.
    assign w_rise = w_level & ~r_p_q;
    assign w_fall = ~w_level & r_p_q;

    // Remember last cycle's level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_q <= 1'b0;
        end else begin
            r_p_q <= w_level;
        end
    end

    // State and millisecond counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, counter and event decisions. A release always wins over a
    // coincident tick, so the terminal tick and the release never both fire.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_press_next       = 1'b0;
        w_release_next     = 1'b0;
        w_click_next       = 1'b0;
        w_long_next        = 1'b0;
        w_repeat_next      = 1'b0;
        w_click_count_next = r_click_count;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_press_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = SHORT;
                end
            end

            SHORT: begin
                if (w_fall) begin
                    w_release_next     = 1'b1;
                    w_click_next       = 1'b1;
                    w_click_count_next = r_click_count + 8'd1;
                    w_state_next       = IDLE;
                end else if (w_tick) begin
                    if (r_cnt == LONG_TERM) begin
                        w_long_next  = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = LONG;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            LONG: begin
                if (w_fall) begin
                    w_release_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (w_tick && REPEAT_EN) begin
                    if (r_cnt == REPEAT_TERM) begin
                        w_repeat_next = 1'b1;
                        w_cnt_next    = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Held covers the press cycle through the release cycle inclusive.
        w_held_next = (w_state_next != IDLE) | w_release_next;
    end

    // Output registers, so every event appears one cycle after its cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_click       <= 1'b0;
            r_long        <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_click_count <= 8'd0;
        end else begin
            r_press       <= w_press_next;
            r_release     <= w_release_next;
            r_click       <= w_click_next;
            r_long        <= w_long_next;
            r_repeat      <= w_repeat_next;
            r_held        <= w_held_next;
            r_click_count <= w_click_count_next;
        end
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.click_pulse   = r_click;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.held          = r_held;
    assign bus.click_count   = r_click_count;

endmodule
